// File: rtl/jtdsp16_sio_rx.sv
// jtdsp16_sio_rx: deserialiser for the DSP16 serial output port.
// It collects a 16-bit MSB-first word and its 8-bit serial address, then
// steers the word into the left or right sample register by address.
//
// Ports:
//   clk, rst_n  : system clock (same domain as the DSP16 core), async active-low reset
//   ock         : serial output clock level from the DSP16 (synchronous to clk)
//   sdi         : serial data, MSB first
//   sadd        : serial address bit, MSB first, meaningful during the first 8 bits
//   old         : output load, low while a frame is active
//   sample/addr : last complete word and the address captured with it
//   sample_stb  : one-clk pulse when sample/addr update
//   left/right  : last word received for LEFT_ADDR / RIGHT_ADDR
//   pair_stb    : one-clk pulse when both channels have been refreshed
//   frame_err   : one-clk pulse when a frame ends early (old high before 16 bits)
module jtdsp16_sio_rx #(
    parameter logic [7:0] LEFT_ADDR  = 8'h00,
    parameter logic [7:0] RIGHT_ADDR = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ock,
    input  logic        sdi,
    input  logic        sadd,
    input  logic        old,
    output logic [15:0] sample,
    output logic [7:0]  addr,
    output logic        sample_stb,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        pair_stb,
    output logic        frame_err
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned ADDR_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_OLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_ock_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_sh_q, data_sh_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic [DATA_W-1:0]   right_q, right_d;
    logic                sample_stb_q, sample_stb_d;
    logic                pair_stb_q, pair_stb_d;
    logic                frame_err_q, frame_err_d;
    logic                left_fresh_q, left_fresh_d;
    logic                right_fresh_q, right_fresh_d;

    logic                posedge_ock_c;
    logic                bit_take_c;
    logic                cnt_full_c;
    logic                shift_en_c;

    // Rising ock qualified by old low is a data bit; with old high it is the load edge.
    assign posedge_ock_c = ock & ~last_ock_q;
    assign bit_take_c    = posedge_ock_c & ~old;
    assign cnt_full_c    = (cnt_q == CNT_W'(WORD_BITS));
    // Bits are only accepted while collecting; DONE and WAIT_OLD drop stray edges.
    assign shift_en_c    = bit_take_c &
                           ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && !cnt_full_c));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bit_take_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A full word wins over old rising in the same cycle.
                if (cnt_full_c) begin
                    state_d = ST_DONE;
                end else if (old) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = old ? ST_IDLE : ST_WAIT_OLD;
            end
            ST_WAIT_OLD: begin
                if (old) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d         = cnt_q;
        data_sh_d     = data_sh_q;
        addr_sh_d     = addr_sh_q;
        sample_d      = sample_q;
        addr_d        = addr_q;
        left_d        = left_q;
        right_d       = right_q;
        left_fresh_d  = left_fresh_q;
        right_fresh_d = right_fresh_q;
        sample_stb_d  = 1'b0;
        pair_stb_d    = 1'b0;
        frame_err_d   = 1'b0;

        if (shift_en_c) begin
            data_sh_d = {data_sh_q[DATA_W-2:0], sdi};
            if (cnt_q < CNT_W'(ADDR_BITS)) begin
                addr_sh_d = {addr_sh_q[ADDR_W-2:0], sadd};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Early load edge: drop the partial word.
        if ((state_q == ST_SHIFT) && !cnt_full_c && old) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
        end

        // Fresh flags are set in DONE, so this fires the cycle after it.
        if (left_fresh_q && right_fresh_q) begin
            pair_stb_d    = 1'b1;
            left_fresh_d  = 1'b0;
            right_fresh_d = 1'b0;
        end

        if (state_q == ST_DONE) begin
            sample_d     = data_sh_q;
            addr_d       = addr_sh_q;
            sample_stb_d = 1'b1;
            cnt_d        = '0;
            if (addr_sh_q == LEFT_ADDR) begin
                left_d       = data_sh_q;
                left_fresh_d = 1'b1;
            end
            if (addr_sh_q == RIGHT_ADDR) begin
                right_d       = data_sh_q;
                right_fresh_d = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ock_q    <= 1'b0;
            cnt_q         <= '0;
            data_sh_q     <= '0;
            addr_sh_q     <= '0;
            sample_q      <= '0;
            addr_q        <= '0;
            left_q        <= '0;
            right_q       <= '0;
            left_fresh_q  <= 1'b0;
            right_fresh_q <= 1'b0;
            sample_stb_q  <= 1'b0;
            pair_stb_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            last_ock_q    <= ock;
            cnt_q         <= cnt_d;
            data_sh_q     <= data_sh_d;
            addr_sh_q     <= addr_sh_d;
            sample_q      <= sample_d;
            addr_q        <= addr_d;
            left_q        <= left_d;
            right_q       <= right_d;
            left_fresh_q  <= left_fresh_d;
            right_fresh_q <= right_fresh_d;
            sample_stb_q  <= sample_stb_d;
            pair_stb_q    <= pair_stb_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign sample     = sample_q;
    assign addr       = addr_q;
    assign sample_stb = sample_stb_q;
    assign left       = left_q;
    assign right      = right_q;
    assign pair_stb   = pair_stb_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Testbench for jtdsp16_sio_rx: directed frames plus randomized traffic, checked
// by a scoreboard fed from a frame-level reference model.
module tb_jtdsp16_sio_rx;

    localparam logic [7:0] LADDR = 8'h00;
    localparam logic [7:0] RADDR = 8'h01;

    logic        clk;
    logic        rst_n;
    logic        ock;
    logic        sdi;
    logic        sadd;
    logic        old;
    logic [15:0] sample;
    logic [7:0]  addr;
    logic        sample_stb;
    logic [15:0] left;
    logic [15:0] right;
    logic        pair_stb;
    logic        frame_err;

    jtdsp16_sio_rx #(.LEFT_ADDR(LADDR), .RIGHT_ADDR(RADDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ock        (ock),
        .sdi        (sdi),
        .sadd       (sadd),
        .old        (old),
        .sample     (sample),
        .addr       (addr),
        .sample_stb (sample_stb),
        .left       (left),
        .right      (right),
        .pair_stb   (pair_stb),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  a;
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } smp_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } pair_t;

    smp_t  smp_q[$];
    pair_t pair_q[$];
    int    err_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference state.
    logic [15:0] m_sample, m_left, m_right;
    logic [7:0]  m_addr;
    bit          m_fl, m_fr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sample = '0; m_addr = '0; m_left = '0; m_right = '0;
        m_fl = 0; m_fr = 0;
    endtask

    // A complete frame updates the model; strobe cycles are predicted from the
    // cycle at which the 16th ock rise is presented.
    task automatic model_frame(input logic [15:0] d, input logic [7:0] a, input int c);
        smp_t  s;
        pair_t p;
        m_sample = d;
        m_addr   = a;
        if (a == LADDR) begin m_left  = d; m_fl = 1; end
        if (a == RADDR) begin m_right = d; m_fr = 1; end
        s.d = d; s.a = a; s.l = m_left; s.r = m_right; s.cyc = c + 3;
        smp_q.push_back(s);
        if (m_fl && m_fr) begin
            p.l = m_left; p.r = m_right; p.cyc = c + 4;
            pair_q.push_back(p);
            m_fl = 0; m_fr = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 0: full frame, 1: old raised after nbits, 2: stop after nbits (caller resets)
    task automatic send_frame(input logic [15:0] d, input logic [7:0] a, input int nbits,
                              input int extra, input int mode, input int hi, input int lo);
        old = 1'b0;
        tick(lo);
        for (int i = 0; i < nbits; i++) begin
            sdi  = d[15-i];
            sadd = (i < 8) ? a[7-i] : 1'($urandom);
            ock  = 1'b1;
            if (i == 15) model_frame(d, a, cyc);
            tick(hi);
            ock = 1'b0;
            tick(lo);
        end
        for (int i = 0; i < extra; i++) begin
            sdi  = 1'($urandom);
            sadd = 1'($urandom);
            ock  = 1'b1;
            tick(hi);
            ock = 1'b0;
            tick(lo);
        end
        if (mode == 2) return;
        old = 1'b1;
        if (mode == 1) err_q.push_back(cyc + 1);
        tick(1);
        ock = 1'b1;   // load edge, carries no data
        tick(hi);
        ock = 1'b0;
        tick(lo + 2);
    endtask

    // Monitor: pops expectations whenever the DUT strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_stb) begin
                if (smp_q.size() == 0) begin
                    chk("unexpected_sample_stb", 32'(sample), 32'hFFFF_FFFF);
                end else begin
                    smp_t s;
                    s = smp_q.pop_front();
                    chk("sample", 32'(sample), 32'(s.d));
                    chk("addr",   32'(addr),   32'(s.a));
                    chk("left",   32'(left),   32'(s.l));
                    chk("right",  32'(right),  32'(s.r));
                    chk("sample_stb_cycle", 32'(cyc), 32'(s.cyc));
                end
            end
            if (pair_stb) begin
                if (pair_q.size() == 0) begin
                    chk("unexpected_pair_stb", 32'(left), 32'hFFFF_FFFF);
                end else begin
                    pair_t p;
                    p = pair_q.pop_front();
                    chk("pair_left",  32'(left),  32'(p.l));
                    chk("pair_right", 32'(right), 32'(p.r));
                    chk("pair_stb_cycle", 32'(cyc), 32'(p.cyc));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_frame_err", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    int c;
                    c = err_q.pop_front();
                    chk("frame_err_cycle", 32'(cyc), 32'(c));
                    chk("err_sample_kept", 32'(sample), 32'(m_sample));
                    chk("err_left_kept",   32'(left),   32'(m_left));
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_sample"}, 32'(sample), 32'h0);
        chk({tag, "_addr"},   32'(addr),   32'h0);
        chk({tag, "_left"},   32'(left),   32'h0);
        chk({tag, "_right"},  32'(right),  32'h0);
        chk({tag, "_strobes"}, 32'({sample_stb, pair_stb, frame_err}), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; ock = 1'b0; sdi = 1'b0; sadd = 1'b0; old = 1'b1;
        model_reset();
        tick(3);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Directed frames at DSP16 timing (ock period 12 clk).
        send_frame(16'hA5C3, 8'h00, 16, 0, 0, 6, 6);
        send_frame(16'h1234, 8'h00, 16, 0, 0, 6, 6);
        send_frame(16'hFEDC, 8'h01, 16, 0, 0, 6, 6);
        send_frame(16'h7777, 8'h00, 16, 0, 0, 6, 6);
        send_frame(16'h8001, 8'h7F, 16, 0, 0, 6, 6);
        send_frame(16'hBEEF, 8'h00, 9,  0, 1, 6, 6);
        send_frame(16'h0F0F, 8'h01, 16, 0, 0, 6, 6);
        send_frame(16'h9999, 8'h00, 16, 3, 0, 6, 6);
        send_frame(16'h5555, 8'h01, 16, 0, 0, 6, 6);
        chk("directed_left",  32'(left),  32'h9999);
        chk("directed_right", 32'(right), 32'h5555);

        // Reset part-way through a frame.
        send_frame(16'hDEAD, 8'h00, 8, 0, 2, 6, 6);
        rst_n = 1'b0;
        old   = 1'b1;
        #1;
        chk_zero("midreset");
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        send_frame(16'h3C3C, 8'h01, 16, 0, 0, 6, 6);
        chk("after_reset_right", 32'(right), 32'h3C3C);
        chk("after_reset_left",  32'(left),  32'h0);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            logic [15:0] d;
            logic [7:0]  a;
            int          sel, hi, lo;
            d   = 16'($urandom);
            sel = int'($urandom_range(0, 3));
            a   = (sel == 0) ? LADDR : (sel == 1) ? RADDR : 8'($urandom);
            hi  = int'($urandom_range(1, 6));
            lo  = int'($urandom_range(1, 6));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                send_frame(d, a, int'($urandom_range(1, 15)), 0, 1, hi, lo);
            else if (sel == 1)
                send_frame(d, a, 16, int'($urandom_range(1, 3)), 0, hi, lo);
            else
                send_frame(d, a, 16, 0, 0, hi, lo);
        end

        tick(10);
        chk("final_left",  32'(left),  32'(m_left));
        chk("final_right", 32'(right), 32'(m_right));
        chk("pending_samples", 32'(smp_q.size()),  32'h0);
        chk("pending_pairs",   32'(pair_q.size()), 32'h0);
        chk("pending_errs",    32'(err_q.size()),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
